lcd_scan_engine: RTL and testbench

//  Display-side counterpart of the lcd_module user interface. Walks display_number over

---
 rtl/lcd_scan_pkg.sv | 36 +++
 rtl/lcd_input_accum.sv | 42 ++++
 rtl/lcd_scan_engine.sv | 152 +++++++++++++++
 tb/tb_lcd_scan_engine.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_scan_pkg.sv
// Shared types and character helpers for the LCD slot scanner.
package lcd_scan_pkg;

    typedef enum logic [2:0] {
        ST_GAP,
        ST_REQ,
        ST_WAIT,
        ST_CAPT,
        ST_EMIT,
        ST_NEXT
    } scan_state_t;

    localparam logic [7:0] CHAR_SPACE   = 8'h20;
    localparam int         NAME_BYTES   = 5;
    localparam int         VALUE_DIGITS = 8;
    localparam int         NUM_COLS     = NAME_BYTES + VALUE_DIGITS;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
        if (nibble < 4'd10)
            return 8'h30 + {4'h0, nibble};
        return 8'h41 + {4'h0, nibble} - 8'd10;
    endfunction

    // Columns 0-4 are name bytes (MSB byte first), 5-12 are value nibbles (MSB first).
    function automatic logic [7:0] col_char(input logic [3:0]  col,
                                            input logic [39:0] name,
                                            input logic [31:0] value);
        logic [7:0] b;
        if (col < 4'(NAME_BYTES)) begin
            b = name[8*(NAME_BYTES-1-int'(col)) +: 8];
            return (b == 8'h00) ? CHAR_SPACE : b;
        end
        return hex_ascii(value[4*(NUM_COLS-1-int'(col)) +: 4]);
    endfunction

endpackage

// File: rtl/lcd_input_accum.sv
// Hex-digit keypad accumulator producing the committed input_valid/input_value pair.
module lcd_input_accum (
    input  logic        clk,
    input  logic        reset,
    input  logic        digit_valid,
    input  logic [3:0]  digit,
    input  logic        digit_clear,
    input  logic        digit_enter,
    output logic        input_valid,
    output logic [31:0] input_value
);

    logic [31:0] acc;
    logic [31:0] acc_next;

    // NOTE: default assignment first so every path drives acc_next and no latch is inferred.
    always_comb begin
        acc_next = acc;
        if (digit_clear)
            acc_next = '0;
        else if (digit_valid)
            acc_next = {acc[27:0], digit};
    end

    // NOTE: state is updated with non-blocking assignments so all flops sample the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc         <= '0;
            input_valid <= 1'b0;
            input_value <= '0;
        end else begin
            input_valid <= digit_enter;
            if (digit_enter) begin
                input_value <= acc_next;
                acc         <= '0;
            end else begin
                acc <= acc_next;
            end
        end
    end

endmodule

// File: rtl/lcd_scan_engine.sv
// Slot scanner and ASCII renderer for the LCD writer; define LCD_SCAN_CHANGE_ONLY_EN
// to emit only slots whose reply changed since they were last shown.
module lcd_scan_engine
    import lcd_scan_pkg::*;
#(
    parameter int NUM_SLOTS  = 44,
    parameter int GAP_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic [5:0]  display_number,
    input  logic        display_valid,
    input  logic [39:0] display_name,
    input  logic [31:0] display_value,
    output logic        char_valid,
    input  logic        char_ready,
    output logic [7:0]  char_data,
    output logic [5:0]  char_slot,
    output logic [3:0]  char_col,
    input  logic        digit_valid,
    input  logic [3:0]  digit,
    input  logic        digit_clear,
    input  logic        digit_enter,
    output logic        input_valid,
    output logic [31:0] input_value
);

    localparam int         GAP_W    = $clog2(GAP_CYCLES + 1);
    localparam logic [3:0] COL_LAST = 4'(NUM_COLS - 1);

    scan_state_t      state;
    logic [GAP_W-1:0] gap_cnt;
    logic             cap_valid;
    logic [39:0]      cap_name;
    logic [31:0]      cap_value;
    logic             handshake;
    logic             unchanged;

    assign handshake = char_valid & char_ready;

`ifdef LCD_SCAN_CHANGE_ONLY_EN
    logic [5:0]  slot_idx;
    logic        emit_done;
    logic        shadow_valid [NUM_SLOTS];
    logic [39:0] shadow_name  [NUM_SLOTS];
    logic [31:0] shadow_value [NUM_SLOTS];

    assign slot_idx  = display_number - 6'd1;
    assign emit_done = (state == ST_EMIT) && handshake && (char_col == COL_LAST);
    assign unchanged = shadow_valid[slot_idx] &&
                       (shadow_name[slot_idx] == cap_name) &&
                       (shadow_value[slot_idx] == cap_value);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++)
                shadow_valid[i] <= 1'b0;
        end else if (emit_done) begin
            shadow_valid[slot_idx] <= 1'b1;
        end
    end

    // NOTE: only the tag bits are reset; the data array is qualified by them and stays reset-free.
    always_ff @(posedge clk) begin
        if (emit_done) begin
            shadow_name[slot_idx]  <= cap_name;
            shadow_value[slot_idx] <= cap_value;
        end
    end
`else
    assign unchanged = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_GAP;
            gap_cnt        <= GAP_W'(GAP_CYCLES);
            display_number <= '0;
            char_valid     <= 1'b0;
            char_data      <= '0;
            char_slot      <= '0;
            char_col       <= '0;
            cap_valid      <= 1'b0;
            cap_name       <= '0;
            cap_value      <= '0;
        end else begin
            case (state)
                ST_GAP: begin
                    if (gap_cnt <= GAP_W'(1)) begin
                        display_number <= 6'd1;
                        state          <= ST_REQ;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                ST_REQ: state <= ST_WAIT;
                // User logic registers its reply, so it is valid by the end of WAIT.
                ST_WAIT: begin
                    cap_valid <= display_valid;
                    cap_name  <= display_name;
                    cap_value <= display_value;
                    state     <= ST_CAPT;
                end
                ST_CAPT: begin
                    if (!cap_valid || unchanged) begin
                        state <= ST_NEXT;
                    end else begin
                        char_valid <= 1'b1;
                        char_col   <= 4'd0;
                        char_slot  <= display_number;
                        char_data  <= col_char(4'd0, cap_name, cap_value);
                        state      <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (handshake) begin
                        if (char_col == COL_LAST) begin
                            char_valid <= 1'b0;
                            state      <= ST_NEXT;
                        end else begin
                            char_col  <= char_col + 4'd1;
                            char_data <= col_char(char_col + 4'd1, cap_name, cap_value);
                        end
                    end
                end
                ST_NEXT: begin
                    if (display_number == 6'(NUM_SLOTS)) begin
                        display_number <= '0;
                        gap_cnt        <= GAP_W'(GAP_CYCLES);
                        state          <= ST_GAP;
                    end else begin
                        display_number <= display_number + 6'd1;
                        state          <= ST_REQ;
                    end
                end
                default: state <= ST_GAP;
            endcase
        end
    end

    lcd_input_accum u_accum (
        .clk         (clk),
        .reset       (reset),
        .digit_valid (digit_valid),
        .digit       (digit),
        .digit_clear (digit_clear),
        .digit_enter (digit_enter),
        .input_valid (input_valid),
        .input_value (input_value)
    );

endmodule

// File: tb/tb_lcd_scan_engine.sv
// Directed bench for lcd_scan_engine: frame rendering, back-pressure, reset, keypad path.
// Define LCD_SCAN_CHANGE_ONLY_EN to exercise the change-only build.
module tb_lcd_scan_engine;

    localparam int NUM_SLOTS  = 44;
    localparam int GAP_CYCLES = 16;
    localparam int WAIT_LIMIT = 5000;

    logic        clk;
    logic        reset;
    logic [5:0]  display_number;
    logic        display_valid;
    logic [39:0] display_name;
    logic [31:0] display_value;
    logic        char_valid;
    logic        char_ready;
    logic [7:0]  char_data;
    logic [5:0]  char_slot;
    logic [3:0]  char_col;
    logic        digit_valid;
    logic [3:0]  digit;
    logic        digit_clear;
    logic        digit_enter;
    logic        input_valid;
    logic [31:0] input_value;

    // User-side reply table; stable between requests, so a direct lookup models the registered reply.
    logic        valid_tab [64];
    logic [39:0] name_tab  [64];
    logic [31:0] value_tab [64];

    assign display_valid = valid_tab[display_number];
    assign display_name  = name_tab[display_number];
    assign display_value = value_tab[display_number];

    lcd_scan_engine #(.NUM_SLOTS(NUM_SLOTS), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clk            (clk),
        .reset          (reset),
        .display_number (display_number),
        .display_valid  (display_valid),
        .display_name   (display_name),
        .display_value  (display_value),
        .char_valid     (char_valid),
        .char_ready     (char_ready),
        .char_data      (char_data),
        .char_slot      (char_slot),
        .char_col       (char_col),
        .digit_valid    (digit_valid),
        .digit          (digit),
        .digit_clear    (digit_clear),
        .digit_enter    (digit_enter),
        .input_valid    (input_valid),
        .input_value    (input_value)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    int checks_total  = 0;
    int checks_passed = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks_total++;
        if (got === want)
            checks_passed++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
    endtask

    logic [7:0] q_data [$];
    logic [5:0] q_slot [$];
    logic [3:0] q_col  [$];

    always @(negedge clk) begin
        if (char_valid && char_ready) begin
            q_data.push_back(char_data);
            q_slot.push_back(char_slot);
            q_col.push_back(char_col);
        end
    end

    task automatic clear_log();
        q_data.delete();
        q_slot.delete();
        q_col.delete();
    endtask

    // Waits on negedges until (display_number==0) equals want_zero.
    task automatic wait_dn(input bit want_zero, input string tag);
        int n = 0;
        bit timed_out = 1'b0;
        while ((display_number == 6'd0) != want_zero) begin
            if (n == WAIT_LIMIT) begin
                timed_out = 1'b1;
                break;
            end
            @(negedge clk);
            n++;
        end
        check(tag, 64'(timed_out), 64'd0);
    endtask

    task automatic wait_col(input logic [3:0] col, input string tag);
        int n = 0;
        bit timed_out = 1'b0;
        while (!(char_valid && char_col == col)) begin
            if (n == WAIT_LIMIT) begin
                timed_out = 1'b1;
                break;
            end
            @(negedge clk);
            n++;
        end
        check(tag, 64'(timed_out), 64'd0);
    endtask

    // Called on a negedge where display_number==0; counts gap cycles including that one.
    task automatic measure_gap(input string tag);
        int n = 1;
        while (n <= WAIT_LIMIT) begin
            @(negedge clk);
            if (display_number != 6'd0)
                break;
            n++;
        end
        check(tag, 64'(n), 64'(GAP_CYCLES));
    endtask

    task automatic check_chars(input string tag, input int base, input logic [5:0] slot,
                               input string text);
        for (int i = 0; i < 13; i++) begin
            if (base + i >= q_data.size()) begin
                check({tag, " short"}, 64'(q_data.size()), 64'(base + i + 1));
                break;
            end
            check({tag, " data"}, 64'(q_data[base+i]), 64'(text[i]));
            check({tag, " slot"}, 64'(q_slot[base+i]), 64'(slot));
            check({tag, " col"},  64'(q_col[base+i]),  64'(i));
        end
    endtask

    task automatic stall_at_col7();
        wait_col(4'd6, "stall reach col6");
        @(posedge clk);
        #1 char_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall valid", 64'(char_valid), 64'd1);
            check("stall data",  64'(char_data),  64'h30);
            check("stall slot",  64'(char_slot),  64'd1);
            check("stall col",   64'(char_col),   64'd7);
        end
        @(posedge clk);
        #1 char_ready = 1'b1;
    endtask

    task automatic key(input bit dv, input logic [3:0] d, input bit clr, input bit ent);
        digit_valid = dv;
        digit       = d;
        digit_clear = clr;
        digit_enter = ent;
        @(negedge clk);
        digit_valid = 1'b0;
        digit_clear = 1'b0;
        digit_enter = 1'b0;
    endtask

    task automatic commit(input string tag, input bit dv, input logic [3:0] d, input bit clr,
                          input logic [31:0] want);
        key(dv, d, clr, 1'b1);
        check({tag, " pulse"}, 64'(input_valid), 64'd1);
        check({tag, " value"}, 64'(input_value), 64'(want));
        @(negedge clk);
        check({tag, " pulse end"}, 64'(input_valid), 64'd0);
        check({tag, " hold"},      64'(input_value), 64'(want));
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            valid_tab[i] = 1'b0;
            name_tab[i]  = '0;
            value_tab[i] = '0;
        end
        valid_tab[1] = 1'b1;
        name_tab[1]  = 40'h00_0000_7331;    // "s1"
        value_tab[1] = 32'h0000_00AF;
`ifdef LCD_SCAN_CHANGE_ONLY_EN
        valid_tab[2] = 1'b1;
        name_tab[2]  = 40'h00_0000_7332;    // "s2"
        value_tab[2] = 32'h0000_0000;
`endif
        reset       = 1'b1;
        char_ready  = 1'b1;
        digit_valid = 1'b0;
        digit       = 4'h0;
        digit_clear = 1'b0;
        digit_enter = 1'b0;

        repeat (3) @(negedge clk);
        check("reset display_number", 64'(display_number), 64'd0);
        check("reset char_valid",     64'(char_valid),     64'd0);
        check("reset char_data",      64'(char_data),      64'd0);
        check("reset char_slot",      64'(char_slot),      64'd0);
        check("reset char_col",       64'(char_col),       64'd0);
        check("reset input_valid",    64'(input_valid),    64'd0);
        check("reset input_value",    64'(input_value),    64'd0);
        reset = 1'b0;

        // Frame 1 with a 5-cycle stall at column 7.
        clear_log();
        fork
            begin
                wait_dn(1'b0, "f1 start");
                wait_dn(1'b1, "f1 end");
            end
            stall_at_col7();
        join
`ifdef LCD_SCAN_CHANGE_ONLY_EN
        check("f1 count", 64'(q_data.size()), 64'd26);
        check_chars("f1 s1", 0, 6'd1, "   s1000000AF");
        check_chars("f1 s2", 13, 6'd2, "   s200000000");
`else
        check("f1 count", 64'(q_data.size()), 64'd13);
        check_chars("f1", 0, 6'd1, "   s1000000AF");
`endif
        measure_gap("f1 gap");

        // Frame 2: static replies.
        clear_log();
        wait_dn(1'b1, "f2 end");
`ifdef LCD_SCAN_CHANGE_ONLY_EN
        check("f2 count", 64'(q_data.size()), 64'd0);
        value_tab[2] = 32'h0000_0001;
        clear_log();
        wait_dn(1'b0, "f3 start");
        wait_dn(1'b1, "f3 end");
        check("f3 count", 64'(q_data.size()), 64'd13);
        check_chars("f3", 0, 6'd2, "   s200000001");
        valid_tab[2] = 1'b0;
`else
        check("f2 count", 64'(q_data.size()), 64'd13);
        check_chars("f2", 0, 6'd1, "   s1000000AF");

        // Frame 3: the live value changes mid-emission; the captured copy must be rendered.
        clear_log();
        fork
            begin
                wait_dn(1'b0, "f3 start");
                wait_dn(1'b1, "f3 end");
            end
            begin
                wait_col(4'd5, "f3 reach col5");
                value_tab[1] = 32'hFFFF_FFFF;
            end
        join
        value_tab[1] = 32'h0000_00AF;
        check("f3 count", 64'(q_data.size()), 64'd13);
        check_chars("f3", 0, 6'd1, "   s1000000AF");
`endif

        // Keypad accumulator.
        @(negedge clk);
        key(1'b1, 4'h1, 1'b0, 1'b0);
        key(1'b1, 4'h2, 1'b0, 1'b0);
        key(1'b1, 4'h3, 1'b0, 1'b0);
        commit("enter 123", 1'b0, 4'h0, 1'b0, 32'h0000_0123);
        commit("acc cleared", 1'b0, 4'h0, 1'b0, 32'h0000_0000);
        for (int d = 1; d <= 9; d++)
            key(1'b1, 4'(d), 1'b0, 1'b0);
        commit("enter 9 digits", 1'b0, 4'h0, 1'b0, 32'h2345_6789);
        key(1'b1, 4'h5, 1'b1, 1'b0);
        commit("digit with clear", 1'b0, 4'h0, 1'b0, 32'h0000_0000);
        key(1'b1, 4'h7, 1'b0, 1'b0);
        commit("enter with clear", 1'b0, 4'h0, 1'b1, 32'h0000_0000);
        key(1'b1, 4'h1, 1'b0, 1'b0);
        commit("enter with digit", 1'b1, 4'h2, 1'b0, 32'h0000_0012);

        // Reset while column 4 is presented and stalled.
`ifdef LCD_SCAN_CHANGE_ONLY_EN
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
`endif
        wait_col(4'd3, "rst reach col3");
        @(posedge clk);
        #1 char_ready = 1'b0;
        @(negedge clk);
        check("rst at col4", 64'(char_col), 64'd4);
        reset = 1'b1;
        @(negedge clk);
        check("rst char_valid",     64'(char_valid),     64'd0);
        check("rst display_number", 64'(display_number), 64'd0);
        check("rst char_col",       64'(char_col),       64'd0);
        reset      = 1'b0;
        char_ready = 1'b1;
        clear_log();
        measure_gap("rst gap");
        wait_dn(1'b1, "rst frame end");
        check("rst frame count", 64'(q_data.size()), 64'd13);
        check_chars("rst frame", 0, 6'd1, "   s1000000AF");

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
